// File: rtl/btn_event_ctrl.sv
// ============================================================================
// btn_event_ctrl
// ----------------------------------------------------------------------------
// Purpose:
//   Turns a debounced button level into events. A new press produces a single
//   cycle press_pulse and advances a wrap-around index. A press held for
//   HOLD_CYCLES cycles raises `hold`, which stays high until release.
//
// Optional feature (compile-time macro BTN_AUTOREPEAT_EN):
//   When the macro is defined, a held button also produces an auto-repeat
//   press_pulse every REPEAT_CYCLES cycles. Each repeat advances the index
//   exactly like a new press. When the macro is undefined, HOLD is a pure
//   wait state and REPEAT_CYCLES has no effect.
//
// Ports:
//   clk         in   1      system clock, rising edge
//   reset       in   1      asynchronous active-high reset
//   db_sig      in   1      debounced button level (1 = pressed), clk-synchronous
//   press_pulse out  1      one-cycle event: new press or auto-repeat tick
//   index       out  IDX_W  current position, advances on every press_pulse
//   hold        out  1      high while a long press is in progress
//
// All outputs are registered.
// ============================================================================
module btn_event_ctrl #(
    parameter int unsigned HOLD_CYCLES   = 25000000,
    parameter int unsigned REPEAT_CYCLES = 5000000,
    parameter int unsigned CNT_W         = 25,
    parameter int unsigned IDX_MAX       = 15,
    parameter int unsigned IDX_W         = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             db_sig,
    output logic             press_pulse,
    output logic [IDX_W-1:0] index,
    output logic             hold
);

    // ------------------------------------------------------------------------
    // Elaboration-time parameter sanity checks
    // ------------------------------------------------------------------------
    if (HOLD_CYCLES < 2 || REPEAT_CYCLES < 1) begin : g_bad_cycles
        $error("btn_event_ctrl: HOLD_CYCLES must be >= 2 and REPEAT_CYCLES >= 1");
    end

    // Terminal timer values, sized to the timer so comparisons are width-exact.
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(IDX_MAX);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PRESS,
        ST_HOLD
    } state_e;

    state_e           state_q,       state_d;
    logic [CNT_W-1:0] timer_q,       timer_d;
    logic             press_pulse_q, press_pulse_d;
    logic [IDX_W-1:0] index_q,       index_d;
    logic             hold_q,        hold_d;
    logic [IDX_W-1:0] index_inc;

    // Wrap-around successor of the current index (no saturation).
    assign index_inc = (index_q == IDX_LAST) ? '0 : index_q + IDX_W'(1);

    // ------------------------------------------------------------------------
    // Next-state / next-output logic
    // ------------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal gets a default first so no path through the case
        // leaves a variable unassigned, which would infer a latch.
        state_d       = state_q;
        timer_d       = timer_q;
        press_pulse_d = 1'b0;
        index_d       = index_q;
        hold_d        = hold_q;

        unique case (state_q)
            ST_IDLE: begin
                if (db_sig) begin
                    state_d       = ST_PRESS;
                    timer_d       = '0;
                    press_pulse_d = 1'b1;
                    index_d       = index_inc;
                end
            end

            ST_PRESS: begin
                // Release is tested first so it wins over a same-edge expiry.
                if (!db_sig) begin
                    state_d = ST_IDLE;
                    timer_d = '0;
                end else if (timer_q == HOLD_LAST) begin
                    state_d = ST_HOLD;
                    hold_d  = 1'b1;
                    timer_d = '0;
                end else begin
                    timer_d = timer_q + CNT_W'(1);
                end
            end

            ST_HOLD: begin
                if (!db_sig) begin
                    state_d = ST_IDLE;
                    hold_d  = 1'b0;
                    timer_d = '0;
                end else begin
`ifdef BTN_AUTOREPEAT_EN
                    if (timer_q == CNT_W'(REPEAT_CYCLES - 1)) begin
                        press_pulse_d = 1'b1;
                        index_d       = index_inc;
                        timer_d       = '0;
                    end else begin
                        timer_d = timer_q + CNT_W'(1);
                    end
`else
                    // Wait state: timer parked at zero, index frozen.
                    timer_d = '0;
`endif
                end
            end

            default: begin
                state_d = ST_IDLE;
                timer_d = '0;
                hold_d  = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // State and output registers
    // ------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            timer_q       <= '0;
            press_pulse_q <= 1'b0;
            index_q       <= '0;
            hold_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            timer_q       <= timer_d;
            press_pulse_q <= press_pulse_d;
            index_q       <= index_d;
            hold_q        <= hold_d;
        end
    end

    assign press_pulse = press_pulse_q;
    assign index       = index_q;
    assign hold        = hold_q;

endmodule

// File: tb/tb_btn_event_ctrl.sv
// ============================================================================
// tb_btn_event_ctrl
// ----------------------------------------------------------------------------
// Scoreboard bench for btn_event_ctrl with HOLD_CYCLES=8, REPEAT_CYCLES=4,
// IDX_MAX=5, IDX_W=3, CNT_W=4. The reference model works purely from the
// length of the current press (edges with db_sig high in a row): the press
// edge is run 1, hold is high once run exceeds HOLD_CYCLES, and with
// BTN_AUTOREPEAT_EN repeats fall every REPEAT_CYCLES edges after that.
// ============================================================================
`timescale 1ns/1ps
module tb_btn_event_ctrl;

    localparam int HOLD_CYCLES   = 8;
    localparam int REPEAT_CYCLES = 4;
    localparam int IDX_MAX       = 5;
    localparam int IDX_W         = 3;
    localparam int CNT_W         = 4;

    logic             clk = 1'b0;
    logic             reset;
    logic             db_sig;
    logic             press_pulse;
    logic [IDX_W-1:0] index;
    logic             hold;

    btn_event_ctrl #(
        .HOLD_CYCLES  (HOLD_CYCLES),
        .REPEAT_CYCLES(REPEAT_CYCLES),
        .CNT_W        (CNT_W),
        .IDX_MAX      (IDX_MAX),
        .IDX_W        (IDX_W)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .db_sig     (db_sig),
        .press_pulse(press_pulse),
        .index      (index),
        .hold       (hold)
    );

    always #5 clk = ~clk;

    typedef struct {
        int pulse;
        int idx;
        int hold;
    } exp_t;

    exp_t exp_q[$];
    int   pulse_q[$];

    int checks   = 0;
    int failures = 0;

    // Reference model state
    int run   = 0;
    int m_idx = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // Predict the outputs after the next rising edge, given db_sig at that edge.
    task automatic model_edge(input logic db);
        exp_t e;
        int   after_hold;
        bit   pulse;
        run   = db ? run + 1 : 0;
        pulse = (run == 1);
        after_hold = run - HOLD_CYCLES - 1;
`ifdef BTN_AUTOREPEAT_EN
        if (after_hold > 0 && (after_hold % REPEAT_CYCLES) == 0) pulse = 1'b1;
`endif
        if (pulse) begin
            m_idx = (m_idx + 1) % (IDX_MAX + 1);
            pulse_q.push_back(m_idx);
        end
        e.pulse = int'(pulse);
        e.idx   = m_idx;
        e.hold  = (run > HOLD_CYCLES) ? 1 : 0;
        exp_q.push_back(e);
    endtask

    task automatic step(input logic db);
        @(negedge clk);
        db_sig = db;
        model_edge(db);
    endtask

    task automatic press(input int hi, input int lo);
        for (int i = 0; i < hi; i++) step(1'b1);
        for (int i = 0; i < lo; i++) step(1'b0);
    endtask

    // ------------------------------------------------------------------------
    // Monitor: pops one expectation per clock, and one index per seen pulse.
    // ------------------------------------------------------------------------
    initial begin
        exp_t e;
        int   want_idx;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("press_pulse", int'(press_pulse), e.pulse);
                check("index", int'(index), e.idx);
                check("hold", int'(hold), e.hold);
            end
            if (press_pulse === 1'b1) begin
                if (pulse_q.size() == 0) begin
                    check("unexpected_pulse", 1, 0);
                end else begin
                    want_idx = pulse_q.pop_front();
                    check("pulse_index", int'(index), want_idx);
                end
            end
        end
    end

    // ------------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------------
    initial begin
        reset  = 1'b1;
        db_sig = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_pulse", int'(press_pulse), 0);
        check("reset_index", int'(index), 0);
        check("reset_hold", int'(hold), 0);
        reset = 1'b0;

        // Build index = 3 with hold = 1, then reset asynchronously.
        press(2, 2);
        press(2, 2);
        press(10, 0);
        @(posedge clk);
        #2;
        check("pre_reset_index", int'(index), 3);
        check("pre_reset_hold", int'(hold), 1);
        reset = 1'b1;
        #1;
        check("async_reset_pulse", int'(press_pulse), 0);
        check("async_reset_index", int'(index), 0);
        check("async_reset_hold", int'(hold), 0);
        db_sig = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        run   = 0;
        m_idx = 0;

        // Short press: one pulse, no hold.
        press(3, 3);
        // Long press: hold (and repeats when the feature is built in).
        press(20, 3);
        // Six quick presses: exercises the index wrap.
        for (int i = 0; i < 6; i++) press(2, 2);
        // Release on the same edge the PRESS timer expires, then re-press.
        press(HOLD_CYCLES, 1);
        press(3, 2);
        // Press one edge longer reaches hold.
        press(HOLD_CYCLES + 1, 1);
        // Single-cycle presses back to back at the minimum spacing.
        for (int i = 0; i < 4; i++) press(1, 1);

        // Randomized bursts.
        for (int i = 0; i < 150; i++) begin
            press(int'($urandom_range(1, 25)), int'($urandom_range(1, 4)));
        end

        press(0, 3);
        @(posedge clk);
        #3;
        check("exp_q_drained", exp_q.size(), 0);
        check("pulse_q_drained", pulse_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/btn_event_ctrl.md
Name: btn_event_ctrl

Overview:
- Downstream consumer of the debouncer's stable output `db_sig`. `db_sig` is a debounced button level: 1 = pressed.
- Converts each press into a single-cycle event pulse and advances a wrap-around index (e.g. 7-segment message rotation position).
- Detects a long press (`hold` flag). Optionally generates auto-repeat events while the button is held.
- Pure synchronous FSM plus counters, single clock domain.

Parameters:
- HOLD_CYCLES, 25000000, press duration (cycles) before `hold` asserts; must be >= 2.
- REPEAT_CYCLES, 5000000, interval (cycles) between auto-repeat events; must be >= 1.
- CNT_W, 25, timer width; 2^CNT_W must be > max(HOLD_CYCLES, REPEAT_CYCLES).
- IDX_MAX, 15, last index value before wrap to 0.
- IDX_W, 4, index width; 2^IDX_W must be > IDX_MAX.

Ports:
- clk, input, 1, system clock, rising edge.
- reset, input, 1, asynchronous, active-high reset.
- db_sig, input, 1, debounced button level from the debouncer, synchronous to clk.
- press_pulse, output, 1, one-cycle event: a new press or an auto-repeat tick.
- index, output, IDX_W, current position; advances on every press_pulse.
- hold, output, 1, high while a long press is in progress.

Behaviour:
- Reset (async, active-high) forces:
  - state = IDLE, timer = 0
  - press_pulse = 0, index = 0, hold = 0
- All outputs are registered. Leaving reset mid-press requires no special handling: if db_sig = 1 at the first edge after reset, that counts as a new press.
- States: IDLE, PRESS, HOLD.
- IDLE:
  - db_sig = 1 at edge k → state = PRESS, timer = 0, press_pulse = 1, index = index + 1 (wrapping).
  - press_pulse is high for exactly the one cycle after edge k. Latency from db_sig rising is 1 clock.
- PRESS:
  - db_sig = 0 → IDLE, timer = 0.
  - Otherwise, if timer == HOLD_CYCLES-1 → HOLD, hold = 1, timer = 0.
  - Otherwise timer = timer + 1.
  - Result: hold rises HOLD_CYCLES cycles after press_pulse rises.
- HOLD:
  - db_sig = 0 → IDLE, hold = 0, timer = 0.
  - Otherwise behaviour depends on the optional feature (see below).
- press_pulse is 0 on every edge not explicitly listed above. It is never high for two consecutive cycles, except when REPEAT_CYCLES = 1 (auto-repeat variant).
- Index wrap: if index == IDX_MAX, the next increment gives 0. There is no saturation.
- Simultaneous release and timer expiry on the same edge: release wins. No state change to HOLD, no pulse, no index change.
- Release followed by re-press:
  - Release takes the FSM to IDLE.
  - db_sig = 1 on the very next edge produces a new press_pulse.
  - Minimum spacing between two presses is therefore 2 cycles.
- The timer never exceeds HOLD_CYCLES-1 or REPEAT_CYCLES-1 and never wraps.

Optional Feature:
- Macro: BTN_AUTOREPEAT_EN
- Defined:
  - In HOLD with db_sig = 1, the timer counts.
  - When timer == REPEAT_CYCLES-1: press_pulse = 1, index = index + 1 (wrapping), timer = 0.
  - The first repeat pulse comes REPEAT_CYCLES cycles after hold rises, then one every REPEAT_CYCLES cycles until release.
- Undefined:
  - HOLD is a wait state: timer is held at 0, no pulses are generated, index is frozen, and hold stays 1 until release.
  - REPEAT_CYCLES is ignored.

Test Plan (HOLD_CYCLES=8, REPEAT_CYCLES=4, IDX_MAX=5, IDX_W=3, CNT_W=4):
- Reset asserted mid-operation with index = 3 and hold = 1 → outputs go immediately (async) to press_pulse = 0, index = 0, hold = 0; state = IDLE.
- db_sig high 3 cycles, then low → exactly one press_pulse, 1 cycle after db_sig rises; index 0→1; hold never asserts.
- db_sig high 20 cycles, macro undefined → one pulse; hold rises 8 cycles after the pulse; index = 1; hold falls 1 cycle after db_sig falls.
- db_sig high 20 cycles, BTN_AUTOREPEAT_EN defined → pulses at cycles 1, 13 and 17 relative to db_sig rise; index ends at 3.
- Six press/release pairs, each 2 cycles high and 2 cycles low → index sequence 1,2,3,4,5,0 (wrap); six single-cycle pulses.
- db_sig falls on the same edge the PRESS timer reaches 7 → no hold, no extra pulse, FSM returns to IDLE; an immediate re-press gives a new pulse 1 cycle later.
